// File: rtl/ram_ctrl.sv
// Initiator-side controller for a 16x32 negedge-clocked RAM: zero-fill sweep after reset,
// alternating arbitration of write/read requests, and a held valid/ready read response.
module ram_ctrl #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 4,
  parameter int DEPTH   = 16,
  parameter int INIT_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              init_done,
  output logic              ram_w_en,
  output logic              ram_r_en,
  output logic [ADDR_W-1:0] ram_addr_w,
  output logic [ADDR_W-1:0] ram_addr_r,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_IDLE = 3'd1,
    ST_WR   = 3'd2,
    ST_RD   = 3'd3,
    ST_RSP  = 3'd4
  } state_t;

  localparam state_t            RST_STATE = (INIT_EN != 0) ? ST_INIT : ST_IDLE;
  localparam logic              RST_DONE  = (INIT_EN != 0) ? 1'b0 : 1'b1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   init_cnt_q, init_cnt_d;
  logic                last_rd_q, last_rd_d;
  logic                w_en_q, w_en_d;
  logic                r_en_q, r_en_d;
  logic [ADDR_W-1:0]   addr_w_q, addr_w_d;
  logic [ADDR_W-1:0]   addr_r_q, addr_r_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                init_done_q, init_done_d;
  logic                wr_fire_s, rd_fire_s;

  // Request acceptance: only in IDLE; a contested cycle goes to whichever side lost last time.
  always_comb begin
    wr_ready = 1'b0;
    rd_ready = 1'b0;
    if (state_q == ST_IDLE) begin
      wr_ready = !rd_valid || last_rd_q;
      rd_ready = !wr_valid || !last_rd_q;
    end else begin
      wr_ready = 1'b0;
      rd_ready = 1'b0;
    end
  end

  assign wr_fire_s = wr_valid && wr_ready;
  assign rd_fire_s = rd_valid && rd_ready;

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    last_rd_d   = last_rd_q;
    w_en_d      = 1'b0;
    r_en_d      = 1'b0;
    addr_w_d    = addr_w_q;
    addr_r_d    = addr_r_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    init_done_d = init_done_q;
    case (state_q)
      ST_INIT: begin
        // The sweep ends on the edge that closes the strobe carrying the last address.
        if (w_en_q && (addr_w_q == LAST_ADDR)) begin
          init_done_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          w_en_d     = 1'b1;
          addr_w_d   = init_cnt_q;
          wdata_d    = '0;
          init_cnt_d = init_cnt_q + ADDR_W'(1);
        end
      end
      ST_IDLE: begin
        if (rd_fire_s) begin
          r_en_d    = 1'b1;
          addr_r_d  = rd_addr;
          last_rd_d = 1'b1;
          state_d   = ST_RD;
        end else if (wr_fire_s) begin
          w_en_d    = 1'b1;
          addr_w_d  = wr_addr;
          wdata_d   = wr_data;
          last_rd_d = 1'b0;
          state_d   = ST_WR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR: begin
        state_d = ST_IDLE;
      end
      ST_RD: begin
        // The RAM drove ram_rdata on the negedge inside the strobe cycle.
        rsp_data_d  = ram_rdata;
        rsp_valid_d = 1'b1;
        state_d     = ST_RSP;
      end
      ST_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RST_STATE;
      init_cnt_q  <= '0;
      last_rd_q   <= 1'b0;
      w_en_q      <= 1'b0;
      r_en_q      <= 1'b0;
      addr_w_q    <= '0;
      addr_r_q    <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      init_done_q <= RST_DONE;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      last_rd_q   <= last_rd_d;
      w_en_q      <= w_en_d;
      r_en_q      <= r_en_d;
      addr_w_q    <= addr_w_d;
      addr_r_q    <= addr_r_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      init_done_q <= init_done_d;
    end
  end

  assign ram_w_en   = w_en_q;
  assign ram_r_en   = r_en_q;
  assign ram_addr_w = addr_w_q;
  assign ram_addr_r = addr_r_q;
  assign ram_wdata  = wdata_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign init_done  = init_done_q;

endmodule

// File: tb/tb_ram_ctrl.sv
// Directed bench for ram_ctrl with a behavioural negedge-clocked 16x32 RAM attached.
module tb_ram_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid, rd_valid, rsp_ready;
  logic        wr_ready, rd_ready, rsp_valid, init_done;
  logic [3:0]  wr_addr, rd_addr, ram_addr_w, ram_addr_r;
  logic [31:0] wr_data, rsp_data, ram_wdata;
  logic [31:0] ram_rdata = 32'h0;
  logic        ram_w_en, ram_r_en;
  logic [31:0] mem [16] = '{default: 32'hA5A5_5A5A};
  logic        both_seen = 1'b0;
  int          tests_run = 0;
  int          tests_failed = 0;

  ram_ctrl #(.DATA_W(32), .ADDR_W(4), .DEPTH(16), .INIT_EN(1)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .init_done(init_done),
    .ram_w_en(ram_w_en), .ram_r_en(ram_r_en),
    .ram_addr_w(ram_addr_w), .ram_addr_r(ram_addr_r),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM model: acts on the negedge between controller posedges.
  always @(negedge clk) begin
    if (ram_w_en) mem[ram_addr_w] <= ram_wdata;
    if (ram_r_en) ram_rdata <= mem[ram_addr_r];
    if (ram_w_en && ram_r_en) both_seen <= 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_wr_ready();
    int n = 0;
    while (!wr_ready && n < 20) begin tick(); n++; end
    if (!wr_ready) begin
      tests_run++; tests_failed++;
      $display("FAIL wr_ready_timeout: wr_ready=%b required 1", wr_ready);
    end
  endtask

  task automatic wait_rd_ready();
    int n = 0;
    while (!rd_ready && n < 20) begin tick(); n++; end
    if (!rd_ready) begin
      tests_run++; tests_failed++;
      $display("FAIL rd_ready_timeout: rd_ready=%b required 1", rd_ready);
    end
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d);
    wr_addr = a; wr_data = d; wr_valid = 1'b1;
    #1;
    wait_wr_ready();
    @(posedge clk); #1;
    wr_valid = 1'b0;
    tick();
  endtask

  task automatic do_read(input logic [3:0] a, output logic [31:0] d);
    int n = 0;
    rd_addr = a; rd_valid = 1'b1;
    #1;
    wait_rd_ready();
    @(posedge clk); #1;
    rd_valid = 1'b0; rsp_ready = 1'b1;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    if (!rsp_valid) begin
      tests_run++; tests_failed++;
      $display("FAIL rsp_valid_timeout: rsp_valid=%b required 1", rsp_valid);
    end
    d = rsp_data;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    wr_valid = 1'b1;
    #1;
    tests_run++;
    if (ram_w_en !== 1'b0 || ram_r_en !== 1'b0 || ram_addr_w !== 4'd0 || ram_addr_r !== 4'd0 ||
        ram_wdata !== 32'd0 || rsp_valid !== 1'b0 || rsp_data !== 32'd0 || init_done !== 1'b0 ||
        wr_ready !== 1'b0 || rd_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_values: w_en=%b r_en=%b aw=%0d ar=%0d wd=%h rv=%b rd=%h done=%b wrdy=%b rrdy=%b required all 0",
               ram_w_en, ram_r_en, ram_addr_w, ram_addr_r, ram_wdata, rsp_valid, rsp_data,
               init_done, wr_ready, rd_ready);
    end
  endtask

  task automatic test_init_sweep();
    logic [31:0] d;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      tests_run++;
      if (ram_w_en !== 1'b1 || ram_addr_w !== 4'(i) || ram_wdata !== 32'd0 || init_done !== 1'b0 ||
          wr_ready !== 1'b0 || rd_ready !== 1'b0 || ram_r_en !== 1'b0) begin
        tests_failed++;
        $display("FAIL init_sweep_%0d: w_en=%b aw=%0d wd=%h done=%b wrdy=%b rrdy=%b required 1,%0d,0,0,0,0",
                 i, ram_w_en, ram_addr_w, ram_wdata, init_done, wr_ready, rd_ready, i);
      end
    end
    tick();
    tests_run++;
    if (ram_w_en !== 1'b0 || init_done !== 1'b1 || wr_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL init_end: w_en=%b done=%b wrdy=%b required 0,1,1", ram_w_en, init_done, wr_ready);
    end
    wr_valid = 1'b0;
    do_read(4'd9, d);
    tests_run++;
    if (d !== 32'd0) begin
      tests_failed++;
      $display("FAIL init_read9: got %h required 00000000", d);
    end
  endtask

  task automatic test_write_read();
    wr_addr = 4'd3; wr_data = 32'hDEAD_BEEF; wr_valid = 1'b1;
    #1;
    tests_run++;
    if (wr_ready !== 1'b1) begin
      tests_failed++; $display("FAIL wr_ready_idle: got %b required 1", wr_ready);
    end
    @(posedge clk); #1;
    wr_valid = 1'b0;
    tests_run++;
    if (ram_w_en !== 1'b1 || ram_r_en !== 1'b0 || ram_addr_w !== 4'd3 ||
        ram_wdata !== 32'hDEAD_BEEF || wr_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL write_strobe: w_en=%b r_en=%b aw=%0d wd=%h wrdy=%b required 1,0,3,deadbeef,0",
               ram_w_en, ram_r_en, ram_addr_w, ram_wdata, wr_ready);
    end
    tick();
    tests_run++;
    if (ram_w_en !== 1'b0 || ram_addr_w !== 4'd3 || ram_wdata !== 32'hDEAD_BEEF) begin
      tests_failed++;
      $display("FAIL write_drop: w_en=%b aw=%0d wd=%h required 0,3,deadbeef", ram_w_en, ram_addr_w, ram_wdata);
    end
    rd_addr = 4'd3; rd_valid = 1'b1;
    #1;
    @(posedge clk); #1;
    rd_valid = 1'b0;
    tests_run++;
    if (ram_r_en !== 1'b1 || ram_w_en !== 1'b0 || ram_addr_r !== 4'd3 || rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL read_strobe: r_en=%b w_en=%b ar=%0d rv=%b required 1,0,3,0", ram_r_en, ram_w_en, ram_addr_r, rsp_valid);
    end
    tick();
    rsp_ready = 1'b1;
    tests_run++;
    if (ram_r_en !== 1'b0 || rsp_valid !== 1'b1 || rsp_data !== 32'hDEAD_BEEF) begin
      tests_failed++;
      $display("FAIL read_rsp: r_en=%b rv=%b rd=%h required 0,1,deadbeef", ram_r_en, rsp_valid, rsp_data);
    end
    tick();
    rsp_ready = 1'b0;
    tests_run++;
    if (rsp_valid !== 1'b0 || rsp_data !== 32'hDEAD_BEEF) begin
      tests_failed++;
      $display("FAIL rsp_consume: rv=%b rd=%h required 0,deadbeef", rsp_valid, rsp_data);
    end
  endtask

  task automatic test_arbitration();
    logic [31:0] d;
    int grant [10];
    int expg  [10] = '{1, 0, 0, 2, 0, 1, 0, 0, 2, 0};
    do_write(4'd6, 32'h0000_0066);
    wr_addr = 4'd5; wr_data = 32'h0000_0055; wr_valid = 1'b1;
    rd_addr = 4'd6; rd_valid = 1'b1; rsp_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      grant[c] = ram_r_en ? 1 : (ram_w_en ? 2 : 0);
      tests_run++;
      if (grant[c] != expg[c]) begin
        tests_failed++;
        $display("FAIL arb_grant_c%0d: grant=%0d required %0d (1=R 2=W)", c, grant[c], expg[c]);
      end
      if (rsp_valid) begin
        tests_run++;
        if (wr_ready !== 1'b0 || rd_ready !== 1'b0 || rsp_data !== 32'h0000_0066) begin
          tests_failed++;
          $display("FAIL arb_rsp_c%0d: wrdy=%b rrdy=%b rd=%h required 0,0,00000066", c, wr_ready, rd_ready, rsp_data);
        end
      end
    end
    wr_valid = 1'b0; rd_valid = 1'b0; rsp_ready = 1'b0;
    do_read(4'd5, d);
    tests_run++;
    if (d !== 32'h0000_0055) begin
      tests_failed++; $display("FAIL arb_readback5: got %h required 00000055", d);
    end
  endtask

  task automatic test_rsp_stall();
    do_write(4'd15, 32'h1234_5678);
    rd_addr = 4'd15; rd_valid = 1'b1;
    wr_addr = 4'd4; wr_data = 32'hBAD0_0004; wr_valid = 1'b1;
    rsp_ready = 1'b0;
    #1;
    tests_run++;
    if (rd_ready !== 1'b1 || wr_ready !== 1'b0) begin
      tests_failed++; $display("FAIL stall_grant: rrdy=%b wrdy=%b required 1,0", rd_ready, wr_ready);
    end
    @(posedge clk); #1;
    for (int j = 1; j <= 5; j++) begin
      tick();
      tests_run++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'h1234_5678 || wr_ready !== 1'b0 || rd_ready !== 1'b0 ||
          ram_w_en !== 1'b0 || ram_r_en !== 1'b0) begin
        tests_failed++;
        $display("FAIL stall_hold_%0d: rv=%b rd=%h wrdy=%b rrdy=%b w_en=%b r_en=%b required 1,12345678,0,0,0,0",
                 j, rsp_valid, rsp_data, wr_ready, rd_ready, ram_w_en, ram_r_en);
      end
    end
    wr_valid = 1'b0; rd_valid = 1'b0; rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tests_run++;
    if (rsp_valid !== 1'b0 || rsp_data !== 32'h1234_5678) begin
      tests_failed++; $display("FAIL stall_release: rv=%b rd=%h required 0,12345678", rsp_valid, rsp_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    wr_addr = 4'd0; wr_data = 32'h0000_0001; wr_valid = 1'b1;
    #1;
    wait_wr_ready();
    @(posedge clk); #1;
    wr_addr = 4'd15; wr_data = 32'h0000_0002;
    tests_run++;
    if (ram_w_en !== 1'b1 || ram_addr_w !== 4'd0 || ram_wdata !== 32'h0000_0001 || wr_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_w0: w_en=%b aw=%0d wd=%h wrdy=%b required 1,0,1,0", ram_w_en, ram_addr_w, ram_wdata, wr_ready);
    end
    tick();
    tests_run++;
    if (ram_w_en !== 1'b0 || wr_ready !== 1'b1) begin
      tests_failed++; $display("FAIL b2b_gap: w_en=%b wrdy=%b required 0,1", ram_w_en, wr_ready);
    end
    tick();
    wr_valid = 1'b0;
    tests_run++;
    if (ram_w_en !== 1'b1 || ram_addr_w !== 4'd15 || ram_wdata !== 32'h0000_0002 || wr_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_w15: w_en=%b aw=%0d wd=%h wrdy=%b required 1,15,2,0", ram_w_en, ram_addr_w, ram_wdata, wr_ready);
    end
    tick();
    do_read(4'd0, d);
    tests_run++;
    if (d !== 32'h0000_0001) begin
      tests_failed++; $display("FAIL b2b_read0: got %h required 00000001", d);
    end
    do_read(4'd15, d);
    tests_run++;
    if (d !== 32'h0000_0002) begin
      tests_failed++; $display("FAIL b2b_read15: got %h required 00000002", d);
    end
  endtask

  task automatic test_reset_midop();
    logic [31:0] d;
    rd_addr = 4'd0; rd_valid = 1'b1; rsp_ready = 1'b0;
    #1;
    wait_rd_ready();
    @(posedge clk); #1;
    rd_valid = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (rsp_valid !== 1'b0 || rsp_data !== 32'd0 || init_done !== 1'b0 || ram_w_en !== 1'b0 ||
        ram_r_en !== 1'b0 || ram_addr_r !== 4'd0 || ram_addr_w !== 4'd0 || ram_wdata !== 32'd0) begin
      tests_failed++;
      $display("FAIL rst_in_rsp: rv=%b rd=%h done=%b w_en=%b r_en=%b ar=%0d aw=%0d wd=%h required all 0",
               rsp_valid, rsp_data, init_done, ram_w_en, ram_r_en, ram_addr_r, ram_addr_w, ram_wdata);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      tests_run++;
      if (ram_w_en !== 1'b1 || ram_addr_w !== 4'(i) || rsp_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL rst_sweep1_%0d: w_en=%b aw=%0d rv=%b required 1,%0d,0", i, ram_w_en, ram_addr_w, rsp_valid, i);
      end
    end
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (ram_w_en !== 1'b0 || ram_addr_w !== 4'd0 || init_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_in_init: w_en=%b aw=%0d done=%b required 0,0,0", ram_w_en, ram_addr_w, init_done);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      tests_run++;
      if (ram_w_en !== 1'b1 || ram_addr_w !== 4'(i) || rsp_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL rst_sweep2_%0d: w_en=%b aw=%0d rv=%b required 1,%0d,0", i, ram_w_en, ram_addr_w, rsp_valid, i);
      end
    end
    tick();
    tests_run++;
    if (init_done !== 1'b1 || ram_w_en !== 1'b0 || rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_sweep2_end: done=%b w_en=%b rv=%b required 1,0,0", init_done, ram_w_en, rsp_valid);
    end
    do_read(4'd15, d);
    tests_run++;
    if (d !== 32'd0) begin
      tests_failed++; $display("FAIL rst_refill15: got %h required 00000000", d);
    end
    tests_run++;
    if (both_seen !== 1'b0) begin
      tests_failed++; $display("FAIL both_enables: seen=%b required 0", both_seen);
    end
  endtask

  initial begin
    rst = 1'b1;
    wr_valid = 1'b0; rd_valid = 1'b0; rsp_ready = 1'b0;
    wr_addr = 4'd0; rd_addr = 4'd0; wr_data = 32'd0;
    #12;
    test_reset();
    test_init_sweep();
    test_write_read();
    test_arbitration();
    test_rsp_stall();
    test_back_to_back();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/ram_ctrl.md
Name: ram_ctrl

Overview:
- Initiator-side controller for the 16x32 negedge-clocked RAM; drives its clk-domain control pins (w_en, r_en, addr_w, addr_r, s_ALU) and captures s_RAM.
- Converts independent valid/ready write and read requests from the ALU datapath into correctly timed single-cycle RAM strobes. Returns read data through a valid/ready response channel.
- Zero-fills the RAM after reset. Never asserts both RAM enables in the same cycle, so the RAM's read-over-write priority is never exercised.

Parameters:
- DATA_W, 32, data width; matches the RAM word.
- ADDR_W, 4, address width.
- DEPTH, 16, number of words, 2**ADDR_W; bounds the init sweep.
- INIT_EN, 1, 1 = zero-fill sweep after reset; 0 = go straight to IDLE.

Ports:
- clk  in  1  system clock; all state updates on posedge (RAM acts on the intervening negedge).
- rst  in  1  asynchronous, active-high reset.
- wr_valid  in  1  write request present.
- wr_ready  out  1  write request accepted this cycle when high with wr_valid.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data (ALU result).
- rd_valid  in  1  read request present.
- rd_ready  out  1  read request accepted this cycle when high with rd_valid.
- rd_addr  in  ADDR_W  read address.
- rsp_valid  out  1  read data valid; held until consumed.
- rsp_ready  in  1  consumer accepts rsp_data.
- rsp_data  out  DATA_W  captured read word.
- init_done  out  1  high once the zero-fill sweep is complete (immediately after reset if INIT_EN=0).
- ram_w_en  out  1  to RAM w_en.
- ram_r_en  out  1  to RAM r_en.
- ram_addr_w  out  ADDR_W  to RAM addr_w.
- ram_addr_r  out  ADDR_W  to RAM addr_r.
- ram_wdata  out  DATA_W  to RAM s_ALU.
- ram_rdata  in  DATA_W  from RAM s_RAM.

Behaviour:
- Clocking and reset: one clock `clk`. Reset `rst` is asynchronous and active-high.
- Reset values:
  - state = INIT if INIT_EN=1, else IDLE.
  - init counter = 0, last_rd = 0.
  - All registered outputs 0: ram_w_en, ram_r_en, ram_addr_w, ram_addr_r, ram_wdata, rsp_valid, rsp_data.
  - init_done = 0 if INIT_EN=1, else 1.
- RAM-side outputs are registers. Strobes last exactly one clk cycle, so each RAM access lands on the single negedge inside that cycle.
- State INIT:
  - ram_w_en is high for DEPTH consecutive cycles, beginning at the first posedge after rst deasserts.
  - ram_addr_w = 0,1,...,DEPTH-1 in order; ram_wdata = 0.
  - At the posedge ending the last sweep write: ram_w_en<=0, init_done<=1, state<=IDLE.
  - wr_ready and rd_ready stay 0 throughout INIT.
- State IDLE:
  - wr_ready = !rd_valid || last_rd.
  - rd_ready = !wr_valid || !last_rd.
  - Both ready signals are combinational from state, last_rd and the opposing valid. They are 0 in every state other than IDLE.
  - When both requests are valid, grants alternate; the first contested grant goes to read.
- Write accept at posedge k:
  - ram_w_en<=1, ram_addr_w<=wr_addr, ram_wdata<=wr_data, last_rd<=0, state<=WR.
  - At posedge k+1: ram_w_en<=0, state<=IDLE.
  - Next accept is possible at posedge k+2. Sustained throughput is one access per 2 cycles.
- Read accept at posedge k:
  - ram_r_en<=1, ram_addr_r<=rd_addr, last_rd<=1, state<=RD.
  - The RAM updates s_RAM on the negedge inside cycle k.
  - At posedge k+1: ram_r_en<=0, rsp_data<=ram_rdata, rsp_valid<=1, state<=RSP.
- State RSP:
  - rsp_valid and rsp_data are held stable until a posedge where rsp_ready=1.
  - At that posedge: rsp_valid<=0, state<=IDLE.
  - rsp_data retains its last value after rsp_valid falls.
  - No new request is accepted while RSP is pending (single outstanding read).
- Invariants:
  - ram_w_en && ram_r_en is never 1.
  - Address and data outputs change only together with their strobe rising; they hold their value when the strobe is low.
- Read-after-write to the same address through two back-to-back accepts returns the new data, because the write negedge precedes the read negedge.
- rst asserted mid-operation: immediate return to reset values.
  - Any in-flight strobe drops asynchronously.
  - A pending response is discarded.
  - With INIT_EN=1, the sweep restarts from address 0.
- Addresses wrap naturally at ADDR_W bits; no range check is needed.

Test Plan:
1. Reset release, INIT_EN=1 -> ram_w_en high 16 consecutive cycles with addr_w 0..15 and wdata 0; init_done rises after the 16th; ready signals low until then. Read addr 9 afterwards -> rsp_data=0.
2. Write addr 3 = 0xDEADBEEF, then read addr 3 with rsp_ready=1 -> ram_w_en for one cycle, then ram_r_en for one cycle; rsp_valid 1 cycle after the read accept with rsp_data=0xDEADBEEF; never both enables high.
3. wr_valid and rd_valid held high continuously with distinct addresses -> grants alternate R,W,R,W; each accept spaced ≥2 cycles; reads stall while RSP is pending.
4. Read addr 15 with rsp_ready low for 5 cycles -> rsp_valid/rsp_data stable for 5 cycles, rd_ready/wr_ready low; clears one posedge after rsp_ready=1.
5. Back-to-back writes to addr 0 (0x1) and addr 15 (0x2), then reads of both -> 0x1 and 0x2; wr_ready low in the cycle after each write accept.
6. Assert rst during RSP and again during INIT sweep at address 7 -> all outputs 0 asynchronously; after release, sweep restarts at address 0; no stale rsp_valid appears.
